// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Issues in-order instruction-memory requests for the current pc, remembers each
// request's pc in a tag FIFO, and buffers returned instructions together with their
// pc in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake.
// A jump flushes the instruction FIFO and arms a drop counter so that responses to
// wrong-path requests still in flight are discarded as they return.
module fetch_unit #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        jump_flag,
    output logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W+1:0] CAPACITY = (PTR_W + 2)'(DEPTH);

    // Occupancy and bookkeeping counters
    logic [PTR_W:0]   occ_reg, occ_next;
    logic [PTR_W:0]   inflight_reg, inflight_next;
    logic [PTR_W:0]   drop_reg, drop_next;

    // Instruction FIFO pointers
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;

    // Tag FIFO pointers (one entry per outstanding request)
    logic [PTR_W-1:0] tag_rd_reg, tag_rd_next;
    logic [PTR_W-1:0] tag_wr_reg, tag_wr_next;

    // Held low through reset and for the first edge after it, so no request
    // leaves while the front end is coming out of reset.
    logic             en_reg;

    // Storage arrays
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      tag_mem  [DEPTH];

    // Per-cycle events
    logic [PTR_W+1:0] load;
    logic             credit;
    logic             fire;
    logic             resp;
    logic             discard;
    logic             push;
    logic             pop;
    logic [31:0]      resp_tag;

    // Request side, response classification and decode handshake
    always_comb begin
        load           = {1'b0, occ_reg} + {1'b0, inflight_reg};
        credit         = en_reg & (load < CAPACITY);
        imem_req_valid = credit & ~jump_flag;
        imem_req_addr  = pc;
        fire           = imem_req_valid & imem_req_ready;
        stall          = ~fire;

        // A response with nothing outstanding is a protocol error and is ignored.
        resp           = imem_resp_valid & (inflight_reg != '0);
        discard        = resp & (jump_flag | (drop_reg != '0));
        push           = resp & ~discard;
        resp_tag       = tag_mem[tag_rd_reg];

        if_valid       = (occ_reg != '0);
        pop            = if_valid & id_ready & ~jump_flag;
        if_pc          = '0;
        if_inst        = '0;
        if (if_valid) begin
            if_pc   = pc_mem[rd_ptr_reg];
            if_inst = inst_mem[rd_ptr_reg];
        end
    end

    // Next-state for counters and pointers
    always_comb begin
        inflight_next = inflight_reg;
        if (fire && !resp) begin
            inflight_next = inflight_reg + CNT_ONE;
        end else if (!fire && resp) begin
            inflight_next = inflight_reg - CNT_ONE;
        end

        // On a jump every request still outstanding after this cycle is wrong-path.
        drop_next = drop_reg;
        if (jump_flag) begin
            drop_next = inflight_next;
        end else if (resp && (drop_reg != '0)) begin
            drop_next = drop_reg - CNT_ONE;
        end

        occ_next    = occ_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (jump_flag) begin
            occ_next    = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end else begin
            if (push && !pop) begin
                occ_next = occ_reg + CNT_ONE;
            end else if (!push && pop) begin
                occ_next = occ_reg - CNT_ONE;
            end
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
        end

        // Tags survive a flush so that dropped responses still retire their entry.
        tag_wr_next = tag_wr_reg;
        tag_rd_next = tag_rd_reg;
        if (fire) begin
            tag_wr_next = tag_wr_reg + PTR_ONE;
        end
        if (resp) begin
            tag_rd_next = tag_rd_reg + PTR_ONE;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_reg       <= 1'b0;
            occ_reg      <= '0;
            inflight_reg <= '0;
            drop_reg     <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            tag_rd_reg   <= '0;
            tag_wr_reg   <= '0;
        end else begin
            en_reg       <= 1'b1;
            occ_reg      <= occ_next;
            inflight_reg <= inflight_next;
            drop_reg     <= drop_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            tag_rd_reg   <= tag_rd_next;
            tag_wr_reg   <= tag_wr_next;
        end
    end

    // Per-entry storage; the head is read combinationally so decode sees it
    // in the same cycle the entry becomes valid.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture the pc of an accepted request into its tag slot
            always_ff @(posedge clk) begin
                if (fire && (tag_wr_reg == PTR_W'(gi))) begin
                    tag_mem[gi] <= pc;
                end
            end

            // Capture a kept response together with the pc it was fetched for
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    pc_mem[gi]   <= resp_tag;
                    inst_mem[gi] <= imem_resp_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand sequences for
// jump/flush and backpressure corners, and a randomized run against a queue model.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        jump_flag;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    fetch_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .jump_flag      (jump_flag),
        .stall          (stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .id_ready       (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;

    // Memory model: accepted requests with the cycle their response is due
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    last_due;
    int    lat;

    // Reference model: outstanding fetches (with wrong-path mark) and decode buffer
    typedef struct { logic [31:0] pc; bit wrong; } live_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    live_t live[$];
    ent_t  buff[$];
    bit    run;
    logic [31:0] pc_r;

    // Current cycle's stimulus and model predictions
    bit          cur_rv, cur_rdy, cur_idr, cur_jmp;
    logic [31:0] cur_tgt;
    bit          exp_rv, exp_fire, exp_iv;

    // Directed vector table
    typedef struct {
        bit rst; bit rdy; bit idr;
        bit e_stall; bit e_rv; logic [31:0] e_addr;
        bit e_iv; logic [31:0] e_pc;
    } vec_t;
    vec_t tv[26];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mk(input bit rst, input bit rdy, input bit idr, input bit e_stall,
                                input bit e_rv, input logic [31:0] e_addr, input bit e_iv,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.idr = idr; v.e_stall = e_stall;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
        end
    endtask

    // Apply one cycle of stimulus; memory responds when a request falls due
    task automatic drive(input bit rv, input bit rdy, input bit idr, input bit jmp,
                         input logic [31:0] tgt);
        cur_rv = rv; cur_rdy = rdy; cur_idr = idr; cur_jmp = jmp; cur_tgt = tgt;
        reset          = rv;
        imem_req_ready = rdy;
        id_ready       = idr;
        jump_flag      = jmp;
        pc             = pc_r;
        if (rv && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
    endtask

    // Compare DUT outputs against the model's prediction for this cycle
    task automatic check_model();
        exp_rv   = cur_rv && run && (buff.size() + live.size() < DEPTH) && !cur_jmp;
        exp_fire = exp_rv && cur_rdy;
        exp_iv   = cur_rv && (buff.size() > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        chk("stall", 32'(stall), 32'(!exp_fire));
        if (exp_rv) chk("req_addr", imem_req_addr, pc_r);
        chk("if_valid", 32'(if_valid), 32'(exp_iv));
        if (exp_iv) begin
            chk("if_pc", if_pc, buff[0].pc);
            chk("if_inst", if_inst, buff[0].inst);
        end else begin
            chk("if_pc_idle", if_pc, 32'h0);
            chk("if_inst_idle", if_inst, 32'h0);
        end
        if (imem_resp_valid) chk("resp_has_req", 32'(live.size() > 0), 32'h1);
    endtask

    // Advance model, memory and PC register across the clock edge
    task automatic commit();
        live_t l;
        ent_t  e;
        mreq_t m;
        bit    pop_ok;
        if (!cur_rv) begin
            live.delete(); buff.delete(); mq.delete();
            run = 1'b0; pc_r = 32'h0; last_due = cyc;
        end else begin
            pop_ok = cur_idr && (buff.size() > 0) && !cur_jmp;
            if (pop_ok) begin
                $display("decode cyc=%0d pc=%h inst=%h", cyc, buff[0].pc, buff[0].inst);
                void'(buff.pop_front());
            end
            if (imem_resp_valid && live.size() > 0) begin
                l = live.pop_front();
                void'(mq.pop_front());
                if (!l.wrong && !cur_jmp) begin
                    e.pc = l.pc; e.inst = mem_word(l.pc);
                    buff.push_back(e);
                end
            end
            if (cur_jmp) begin
                foreach (live[i]) live[i].wrong = 1'b1;
                buff.delete();
            end
            if (exp_fire) begin
                l.pc = pc_r; l.wrong = 1'b0;
                live.push_back(l);
            end
            if (imem_req_valid && imem_req_ready) begin
                m.addr = imem_req_addr;
                m.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = m.due;
                mq.push_back(m);
            end
            if (cur_jmp) pc_r = cur_tgt;
            else if (exp_fire) pc_r = pc_r + 32'd4;
            run = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit rv, input bit rdy, input bit idr, input bit jmp,
                        input logic [31:0] tgt);
        drive(rv, rdy, idr, jmp, tgt);
        check_model();
        commit();
    endtask

    initial begin
        bit          seen;
        logic [31:0] held;

        total = 0; bad = 0; cyc = 0; last_due = 0; lat = 1;
        run = 1'b0; pc_r = 32'h0;
        reset = 1'b0; pc = '0; jump_flag = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; id_ready = 1'b0;

        // rst, rdy, idr | stall, req_valid, addr | if_valid, if_pc   (memory latency 1)
        // Fill with decode blocked: exactly four fires, then one pop frees one slot.
        tv[0]  = mk(0,1,0, 1,0,32'h00, 0,32'h0);
        tv[1]  = mk(1,1,0, 1,0,32'h00, 0,32'h0);
        tv[2]  = mk(1,1,0, 0,1,32'h00, 0,32'h0);
        tv[3]  = mk(1,1,0, 0,1,32'h04, 0,32'h0);
        tv[4]  = mk(1,1,0, 0,1,32'h08, 1,32'h0);
        tv[5]  = mk(1,1,0, 0,1,32'h0C, 1,32'h0);
        tv[6]  = mk(1,1,0, 1,0,32'h00, 1,32'h0);
        tv[7]  = mk(1,1,0, 1,0,32'h00, 1,32'h0);
        tv[8]  = mk(1,1,1, 1,0,32'h00, 1,32'h0);
        tv[9]  = mk(1,1,0, 0,1,32'h10, 1,32'h4);
        tv[10] = mk(1,1,0, 1,0,32'h00, 1,32'h4);
        tv[11] = mk(1,1,0, 1,0,32'h00, 1,32'h4);
        // Reset mid-run with three buffered and one outstanding fetch.
        tv[12] = mk(0,1,0, 1,0,32'h00, 0,32'h0);
        tv[13] = mk(1,1,0, 1,0,32'h00, 0,32'h0);
        tv[14] = mk(1,1,0, 0,1,32'h00, 0,32'h0);
        tv[15] = mk(1,1,0, 0,1,32'h04, 0,32'h0);
        tv[16] = mk(1,1,0, 0,1,32'h08, 1,32'h0);
        tv[17] = mk(1,1,0, 0,1,32'h0C, 1,32'h0);
        tv[18] = mk(0,1,0, 1,0,32'h00, 0,32'h0);
        // Streaming at one instruction per cycle after release.
        tv[19] = mk(1,1,1, 1,0,32'h00, 0,32'h0);
        tv[20] = mk(1,1,1, 0,1,32'h00, 0,32'h0);
        tv[21] = mk(1,1,1, 0,1,32'h04, 0,32'h0);
        tv[22] = mk(1,1,1, 0,1,32'h08, 1,32'h0);
        tv[23] = mk(1,1,1, 0,1,32'h0C, 1,32'h4);
        tv[24] = mk(1,1,1, 0,1,32'h10, 1,32'h8);
        tv[25] = mk(1,1,1, 0,1,32'h14, 1,32'hC);

        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            drive(tv[i].rst, tv[i].rdy, tv[i].idr, 1'b0, 32'h0);
            check_model();
            chk($sformatf("row%0d_stall", i), 32'(stall), 32'(tv[i].e_stall));
            chk($sformatf("row%0d_req_valid", i), 32'(imem_req_valid), 32'(tv[i].e_rv));
            if (tv[i].e_rv) chk($sformatf("row%0d_addr", i), imem_req_addr, tv[i].e_addr);
            chk($sformatf("row%0d_if_valid", i), 32'(if_valid), 32'(tv[i].e_iv));
            if (tv[i].e_iv) chk($sformatf("row%0d_if_pc", i), if_pc, tv[i].e_pc);
            commit();
        end

        // Two requests in flight (0x10, 0x14) when jumping to 0x100
        lat = 3;
        step(0, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 1, 32'h10);
        step(1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 0, 32'h0);
        drive(1, 1, 1, 1, 32'h100);
        check_model();
        chk("t4_jump_no_req", 32'(imem_req_valid), 32'h0);
        commit();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(1, 1, 1, 0, 32'h0);
            check_model();
            if (if_valid) begin
                chk("t4_first_pc", if_pc, 32'h100);
                seen = 1'b1;
            end
            commit();
        end
        chk("t4_seen", 32'(seen), 32'h1);

        // Jump coinciding with a response and a decode pop
        lat = 2;
        step(0, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 32'h0);
        drive(1, 1, 1, 1, 32'h300);
        check_model();
        chk("t5_head_before", 32'(if_valid), 32'h1);
        commit();
        drive(1, 1, 1, 0, 32'h0);
        check_model();
        chk("t5_empty_after", 32'(if_valid), 32'h0);
        commit();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            drive(1, 1, 1, 0, 32'h0);
            check_model();
            if (if_valid) begin
                chk("t5_first_pc", if_pc, 32'h300);
                seen = 1'b1;
            end
            commit();
        end
        chk("t5_seen", 32'(seen), 32'h1);

        // Memory refuses requests for five cycles: PC must hold
        for (int k = 0; k < 8; k++) step(1, 0, 1, 0, 32'h0);
        held = pc_r;
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 1, 0, 32'h0);
            check_model();
            chk("t6_stall", 32'(stall), 32'h1);
            chk("t6_req_valid", 32'(imem_req_valid), 32'h1);
            chk("t6_addr_held", imem_req_addr, held);
            commit();
        end
        drive(1, 1, 1, 0, 32'h0);
        check_model();
        chk("t6_fire", 32'(stall), 32'h0);
        chk("t6_fire_addr", imem_req_addr, held);
        commit();

        // Randomized traffic with varying latency, backpressure and jumps
        for (int ph = 0; ph < 6; ph++) begin
            lat = $urandom_range(1, 6);
            for (int k = 0; k < 300; k++) begin
                step(1, ($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
                     $urandom & 32'hFFFF_FFFC);
            end
        end
        // Let everything drain
        for (int k = 0; k < 20; k++) step(1, 1, 1, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
